pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width in bits (legal range 1..1024).
REQ-002 Parameter CNT_W, default 16, SHALL set the stall-counter width (legal range 4..32).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low; deassertion SHALL be synchronous to clk.
REQ-005 flush  input  1  SHALL be a synchronous discard of all held entries, active-high.
REQ-006 in_valid  input  1  SHALL indicate the upstream stage offers in_data.
REQ-007 in_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-008 in_data  input  DATA_W  SHALL carry the upstream payload (packed decode fields).
REQ-009 out_valid  output  1  SHALL indicate out_data holds a valid entry.
REQ-010 out_ready  input  1  SHALL indicate the downstream stage accepts out_data.
REQ-011 out_data  output  DATA_W  SHALL carry the payload to the downstream stage.
REQ-012 occupancy  output  2  SHALL report the held entry count: 0, 1 or 2.
REQ-013 stall_cnt  output  CNT_W  SHALL report the number of backpressured cycles.

Function
REQ-014 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 Storage SHALL be two entries: main (drives out_data) and skid.
REQ-016 States SHALL be EMPTY, ONE and FULL.
REQ-017 out_valid SHALL be 1 in ONE or FULL and SHALL be driven from a register.
REQ-018 in_ready SHALL be 0 only in FULL; it SHALL be driven from a register with no combinational path from in_valid or out_ready.
REQ-019 EMPTY, in_fire: next state ONE; main <= in_data.
REQ-020 ONE, in_fire & out_fire: stay in ONE; main <= in_data.
REQ-021 ONE, in_fire only: next state FULL; skid <= in_data; main unchanged.
REQ-022 ONE, out_fire only: next state EMPTY; main <= 0.
REQ-023 FULL, out_fire: next state ONE; main <= skid; skid <= 0.
REQ-024 Without out_fire, FULL SHALL hold main and skid unchanged.
REQ-025 Latency SHALL be 1 cycle from in_fire to out_valid; sustained throughput SHALL be 1 transfer per cycle when out_ready = 1.
REQ-026 Ordering SHALL be FIFO; no entry SHALL be lost or duplicated.
REQ-027 While out_valid & !out_ready, out_data SHALL remain stable.
REQ-028 When out_valid = 0, out_data SHALL be all-zero (bubble).
REQ-029 flush SHALL take priority over all other events: next state EMPTY, main and skid <= 0.
REQ-030 An in_fire in the same cycle as flush SHALL be discarded.
REQ-031 out_fire in a flush cycle SHALL complete normally downstream; the block's next state SHALL still be EMPTY.
REQ-032 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL respectively.
REQ-033 stall_cnt SHALL increment by 1 in every cycle where out_valid & !out_ready, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.

Reset
REQ-034 rst_n low SHALL immediately force: state EMPTY, main = 0, skid = 0, out_valid = 0, in_ready = 1, occupancy = 0, stall_cnt = 0.
REQ-035 Reset asserted mid-transfer SHALL discard all held entries; the first edge after deassertion SHALL behave as EMPTY.

Verification
REQ-036 Streaming: out_ready = 1; present in_data 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 one cycle later each; occupancy stays 1; stall_cnt = 0.
REQ-037 Backpressure: out_ready = 0; offer 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 accepted; in_ready = 0 after the second accept; 0xA3 held upstream; occupancy = 2. Then out_ready = 1 -> output order 0xA1, 0xA2, 0xA3; no loss.
REQ-038 Flush while FULL with in_valid = 1 in the same cycle -> next cycle out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1; the concurrent input does not appear at the output.
REQ-039 Saturation: CNT_W = 4; hold out_valid = 1, out_ready = 0 for 20 cycles -> stall_cnt = 15, held there.
REQ-040 Async reset: pull rst_n low between clock edges while FULL -> outputs reach reset values before the next edge; after release, 0x5 is accepted and appears at out_data 1 cycle later.
REQ-041 Parameter sweep: DATA_W = 1 and DATA_W = 128 under random valid/ready traffic -> scoreboard match with zero mismatches over 10k transfers.

Source files
------------

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_skid_reg : two-entry skid register for a valid/ready pipeline stage |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_nx;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_nx;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    main_nx  = main_data;
    skid_nx  = skid_data;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = '0;
      skid_nx  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nx = ONE;
            main_nx  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nx = in_data;
          end else if (in_fire) begin
            state_nx = FULL;
            skid_nx  = in_data;
          end else if (out_fire) begin
            state_nx = EMPTY;
            main_nx  = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move
          if (out_fire) begin
            state_nx = ONE;
            main_nx  = skid_data;
            skid_nx  = '0;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = '0;
          skid_nx  = '0;
        end
      endcase
    end
  end

  // Handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      main_data <= main_nx;
      skid_data <= skid_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign out_data  = main_data;
  assign occupancy = state;

endmodule
`default_nettype wire
